// File: rtl/matrix_frame_scheduler.sv
// Double-buffered 8x8 RGB frame store: arbitrates two pixel writers into the back
// buffer, serves pipelined row reads from the front buffer, swaps at frame boundaries.
// Build option: MATRIX_SCHED_COPY_EN adds a 64-cycle front-to-back copy after each swap.
module matrix_frame_scheduler #(
  parameter int FIRST_PRIORITY = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_a_valid,
  output logic        wr_a_ready,
  input  logic [5:0]  wr_a_addr,
  input  logic [2:0]  wr_a_rgb,
  input  logic        wr_b_valid,
  output logic        wr_b_ready,
  input  logic [5:0]  wr_b_addr,
  input  logic [2:0]  wr_b_rgb,
  input  logic        swap_req,
  output logic        swap_pending,
  output logic        swap_done,
  input  logic        scan_active,
  input  logic        scan_req,
  input  logic [2:0]  scan_row,
  output logic        scan_valid,
  output logic [23:0] scan_data,
  output logic        busy
);

  // state | meaning
  // IDLE  | writes granted into back buffer, waiting for a frame boundary
  // SWAP  | one cycle after the boundary; front/back already exchanged
  // COPY  | new front copied into new back, one pixel per cycle (copy build only)
  typedef enum logic [1:0] {
    IDLE,
    SWAP
`ifdef MATRIX_SCHED_COPY_EN
    , COPY
`endif
  } state_t;

  state_t      state_q;
  logic        front_sel_q;
  logic        swap_pending_q;
  logic        last_grant_q;
  logic        swap_done_q;
`ifdef MATRIX_SCHED_COPY_EN
  logic [5:0]  copy_idx_q;
`endif

  logic [2:0]  buf0_q [64];
  logic [2:0]  buf1_q [64];

  logic        boundary;
  logic        grant_a;
  logic        grant_b;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [2:0]  wr_rgb;

  logic        rd_req_q;
  logic        rd_sel_q;
  logic [2:0]  rd_row_q;
  logic        scan_valid_q;
  logic [23:0] scan_data_q;
  logic [23:0] row_data;

  // Writes are blocked in the boundary cycle so nothing lands in the buffer being promoted.
  always_comb begin
    boundary = 1'b0;
    grant_a  = 1'b0;
    grant_b  = 1'b0;
    if (state_q == IDLE && swap_pending_q)
      boundary = scan_active ? (scan_req && scan_row == 3'd7) : 1'b1;
    if (reset_n && state_q == IDLE && !boundary) begin
      if (wr_a_valid && wr_b_valid) begin
        grant_a = last_grant_q;
        grant_b = !last_grant_q;
      end else begin
        grant_a = wr_a_valid;
        grant_b = wr_b_valid;
      end
    end
  end

  always_comb begin
    wr_en   = grant_a | grant_b;
    wr_addr = grant_b ? wr_b_addr : wr_a_addr;
    wr_rgb  = grant_b ? wr_b_rgb  : wr_a_rgb;
`ifdef MATRIX_SCHED_COPY_EN
    if (state_q == COPY) begin
      wr_en   = 1'b1;
      wr_addr = copy_idx_q;
      wr_rgb  = front_sel_q ? buf1_q[copy_idx_q] : buf0_q[copy_idx_q];
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 64; i++) begin
        buf0_q[i] <= '0;
        buf1_q[i] <= '0;
      end
    end else if (wr_en) begin
      if (front_sel_q) buf0_q[wr_addr] <= wr_rgb;
      else             buf1_q[wr_addr] <= wr_rgb;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      front_sel_q    <= 1'b0;
      swap_pending_q <= 1'b0;
      last_grant_q   <= (FIRST_PRIORITY == 0);
      swap_done_q    <= 1'b0;
`ifdef MATRIX_SCHED_COPY_EN
      copy_idx_q     <= '0;
`endif
    end else begin
      swap_done_q <= (state_q == SWAP);
      if (grant_a || grant_b) last_grant_q <= grant_b;
      case (state_q)
        IDLE: begin
          if (boundary) begin
            state_q        <= SWAP;
            front_sel_q    <= !front_sel_q;
            swap_pending_q <= 1'b0;
          end else begin
            swap_pending_q <= swap_pending_q | swap_req;
          end
        end
        SWAP: begin
          swap_pending_q <= swap_pending_q | swap_req;
`ifdef MATRIX_SCHED_COPY_EN
          state_q    <= COPY;
          copy_idx_q <= '0;
`else
          state_q    <= IDLE;
`endif
        end
`ifdef MATRIX_SCHED_COPY_EN
        COPY: begin
          swap_pending_q <= swap_pending_q | swap_req;
          copy_idx_q     <= copy_idx_q + 6'd1;
          if (copy_idx_q == 6'd63) state_q <= IDLE;
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  // Row gather from the front buffer captured at the request edge.
  always_comb begin
    row_data = '0;
    for (int c = 0; c < 8; c++) begin
      logic [2:0] pix;
      pix = rd_sel_q ? buf1_q[{rd_row_q, 3'(c)}] : buf0_q[{rd_row_q, 3'(c)}];
      row_data[16 + c] = pix[2];
      row_data[8 + c]  = pix[1];
      row_data[c]      = pix[0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_req_q     <= 1'b0;
      rd_sel_q     <= 1'b0;
      rd_row_q     <= '0;
      scan_valid_q <= 1'b0;
      scan_data_q  <= '0;
    end else begin
      rd_req_q     <= scan_req;
      scan_valid_q <= rd_req_q;
      if (scan_req) begin
        rd_sel_q <= front_sel_q;
        rd_row_q <= scan_row;
      end
      if (rd_req_q) scan_data_q <= row_data;
    end
  end

  assign wr_a_ready   = grant_a;
  assign wr_b_ready   = grant_b;
  assign swap_pending = swap_pending_q;
  assign swap_done    = swap_done_q;
  assign scan_valid   = scan_valid_q;
  assign scan_data    = scan_data_q;
  assign busy         = (state_q != IDLE);

endmodule
